// File: rtl/arb_pkg.sv
// Shared types and defaults for the external memory bus arbiter.
// Field widths here match the PPU's view of the byte-wide memory port.
package arb_pkg;

  typedef enum logic [1:0] {
    ArbIdle,
    ArbAccess,
    ArbHold
  } ArbState;

  localparam int DEFAULT_MAX_BURST = 16;
  localparam int DEFAULT_TIMEOUT   = 255;

  localparam int MEM_ADDR_W = 32;
  localparam int MEM_DATA_W = 8;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin priority encoder: first set request at or after ptr, wrapping.
// Zero latency; no backpressure.
module rr_pick #(
  parameter int N     = 3,
  parameter int PTR_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req,
  input  logic [PTR_W-1:0] ptr,
  output logic [N-1:0]     grant,
  output logic             valid
);

  always_comb begin
    int   idx;
    logic found;
    grant = '0;
    found = 1'b0;
    idx   = 0;
    for (int i = 0; i < N; i++) begin
      idx = (int'(ptr) + i) % N;
      if (!found && req[idx]) begin
        grant[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end

  assign valid = |req;

endmodule

// File: rtl/mem_bus_arbiter.sv
// Round-robin owner of the byte-wide memory port with capped locked bursts and a hung-memory timeout.
// Strobe one edge after a request; i_mem_valid stalls a beat; i_enable low freezes everything.
module mem_bus_arbiter
  import arb_pkg::*;
#(
  parameter int NUM_REQ   = 3,
  parameter int ADDR_W    = MEM_ADDR_W,
  parameter int MAX_BURST = DEFAULT_MAX_BURST,
  parameter int TIMEOUT   = DEFAULT_TIMEOUT
) (
  input  logic                        i_clock,
  input  logic                        i_reset,
  input  logic                        i_enable,
  input  logic [NUM_REQ-1:0]          i_req,
  input  logic [NUM_REQ-1:0]          i_lock,
  input  logic [NUM_REQ-1:0]          i_write,
  input  logic [NUM_REQ*ADDR_W-1:0]   i_addr,
  input  logic [NUM_REQ*8-1:0]        i_wdata,
  output logic [NUM_REQ-1:0]          o_grant,
  output logic [NUM_REQ-1:0]          o_ack,
  output logic [NUM_REQ-1:0]          o_error,
  output logic [7:0]                  o_rdata,
  output logic                        o_mem_read,
  output logic                        o_mem_write,
  output logic [ADDR_W-1:0]           o_mem_address,
  output logic [7:0]                  o_mem_wdata,
  output logic                        o_mem_drive,
  input  logic                        i_mem_valid,
  input  logic [7:0]                  i_mem_rdata
);

  localparam int PTR_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int BEAT_W = $clog2(MAX_BURST + 1);
  localparam int TMO_W  = $clog2(TIMEOUT + 1);

  ArbState             state, state_n;
  logic [PTR_W-1:0]    rr_ptr, ptr_n;
  logic [PTR_W-1:0]    gidx, gidx_n;
  logic [BEAT_W-1:0]   beats, beats_n;
  logic [TMO_W-1:0]    tmo, tmo_n, tmo_inc;
  logic [NUM_REQ-1:0]  grant_n, ack_n, err_n;
  logic [7:0]          rdata_n, wdata_n;
  logic                rd_n, wr_n;
  logic [ADDR_W-1:0]   addr_n;
  logic [NUM_REQ-1:0]  pick_oh;
  logic                pick_vld;
  logic [PTR_W-1:0]    pick_idx;
  logic [PTR_W-1:0]    next_ptr;

  rr_pick #(.N(NUM_REQ), .PTR_W(PTR_W)) u_rr_pick (
    .req   (i_req),
    .ptr   (rr_ptr),
    .grant (pick_oh),
    .valid (pick_vld)
  );

  always_comb begin
    pick_idx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (pick_oh[i]) pick_idx = PTR_W'(i);
    end
  end

  // After the owner releases, the search starts just past it.
  assign next_ptr = (gidx == PTR_W'(NUM_REQ - 1)) ? '0 : gidx + PTR_W'(1);
  assign tmo_inc  = tmo + TMO_W'(1);

  always_comb begin
    state_n = state;
    ptr_n   = rr_ptr;
    gidx_n  = gidx;
    beats_n = beats;
    tmo_n   = tmo;
    grant_n = o_grant;
    ack_n   = '0;
    err_n   = '0;
    rdata_n = o_rdata;
    rd_n    = o_mem_read;
    wr_n    = o_mem_write;
    addr_n  = o_mem_address;
    wdata_n = o_mem_wdata;
    case (state)
      ArbIdle: begin
        if (pick_vld) begin
          gidx_n  = pick_idx;
          grant_n = pick_oh;
          addr_n  = i_addr[pick_idx*ADDR_W +: ADDR_W];
          wdata_n = i_wdata[pick_idx*8 +: 8];
          wr_n    = i_write[pick_idx];
          rd_n    = !i_write[pick_idx];
          tmo_n   = '0;
          beats_n = '0;
          state_n = ArbAccess;
        end
      end
      ArbAccess: begin
        if (i_mem_valid) begin
          rd_n        = 1'b0;
          wr_n        = 1'b0;
          if (o_mem_read) rdata_n = i_mem_rdata;
          ack_n[gidx] = 1'b1;
          beats_n     = beats + BEAT_W'(1);
          state_n     = ArbHold;
        end else begin
          tmo_n = tmo_inc;
          if (tmo_inc == TMO_W'(TIMEOUT)) begin
            rd_n        = 1'b0;
            wr_n        = 1'b0;
            err_n[gidx] = 1'b1;
            grant_n     = '0;
            ptr_n       = next_ptr;
            state_n     = ArbIdle;
          end
        end
      end
      ArbHold: begin
        // The ack cycle doubles as the bubble where the owner presents its next beat.
        if (i_req[gidx] && i_lock[gidx] && (beats < BEAT_W'(MAX_BURST))) begin
          addr_n  = i_addr[gidx*ADDR_W +: ADDR_W];
          wdata_n = i_wdata[gidx*8 +: 8];
          wr_n    = i_write[gidx];
          rd_n    = !i_write[gidx];
          tmo_n   = '0;
          state_n = ArbAccess;
        end else begin
          grant_n = '0;
          ptr_n   = next_ptr;
          state_n = ArbIdle;
        end
      end
      default: state_n = ArbIdle;
    endcase
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      state         <= ArbIdle;
      rr_ptr        <= '0;
      gidx          <= '0;
      beats         <= '0;
      tmo           <= '0;
      o_grant       <= '0;
      o_ack         <= '0;
      o_error       <= '0;
      o_rdata       <= '0;
      o_mem_read    <= 1'b0;
      o_mem_write   <= 1'b0;
      o_mem_address <= '0;
      o_mem_wdata   <= '0;
      o_mem_drive   <= 1'b0;
    end else if (i_enable) begin
      state         <= state_n;
      rr_ptr        <= ptr_n;
      gidx          <= gidx_n;
      beats         <= beats_n;
      tmo           <= tmo_n;
      o_grant       <= grant_n;
      o_ack         <= ack_n;
      o_error       <= err_n;
      o_rdata       <= rdata_n;
      o_mem_read    <= rd_n;
      o_mem_write   <= wr_n;
      o_mem_address <= addr_n;
      o_mem_wdata   <= wdata_n;
      o_mem_drive   <= wr_n;
    end
  end

endmodule
